// File: rtl/spi_sram_prefetch.sv
// rtl/spi_sram_prefetch.sv - read-ahead word FIFO between the SPI controller and the SRAM arbiter
//
// Purpose: when a burst read starts, this block fetches sequential 16-bit SRAM
// words through the arbiter's req/ack port. It keeps them in a small circular
// FIFO so the SPI side can pop words without waiting on arbitration for each one.
// Write traffic does not pass through this block.
//
// Optional feature: define PREFETCH_STATS_EN to add the underrun_count port.
// This port is a saturating count of pops made while the FIFO was empty.
//
// Ports:
//   clk200          in   1       single 200 MHz clock
//   reset_n         in   1       asynchronous active-low reset
//   rd_start        in   1       pulse: flush, begin burst at start_address
//   start_address   in   ADDR_W  burst start word address (sampled with rd_start)
//   rd_stop         in   1       pulse: end burst, flush FIFO
//   rd_pop          in   1       pulse: consume head word
//   rd_valid        out  1       FIFO non-empty
//   rd_data         out  16      registered head word
//   underrun        out  1       sticky empty-pop flag, cleared by rd_start
//   sram_req        out  1       request to arbiter
//   sram_ack        in   1       completion pulse from arbiter
//   sram_address    out  ADDR_W  request word address, stable while sram_req=1
//   sram_in         in   16      read data, valid with sram_ack
//   underrun_count  out  16      (PREFETCH_STATS_EN only) saturating empty-pop count

module spi_sram_prefetch #(
  parameter int DEPTH_LOG2 = 2,
  parameter int ADDR_W     = 20
) (
  input  logic              clk200,
  input  logic              reset_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] start_address,
  input  logic              rd_stop,
  input  logic              rd_pop,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  output logic              underrun,
  output logic              sram_req,
  input  logic              sram_ack,
  output logic [ADDR_W-1:0] sram_address,
  input  logic [15:0]       sram_in
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]       underrun_count
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [ADDR_W-1:0]     ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  active_q, active_d;
  logic                  discard_q, discard_d;
  logic [ADDR_W-1:0]     next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic [15:0]           mem_q [DEPTH];
  logic [15:0]           mem_d [DEPTH];

  logic                  flush;
  logic                  ack_fetch;
  logic                  push;
  logic                  pop;
  logic                  empty_pop;
  logic [ADDR_W-1:0]     issue_addr;

  always_comb begin
    flush     = rd_start | rd_stop;
    ack_fetch = (state_q == S_FETCH) && sram_ack;
    // A flush in the ack cycle beats the push; a stale (discarded) ack never pushes.
    push      = ack_fetch && !discard_q && !flush;
    pop       = rd_pop && (count_q != '0) && !flush;
    empty_pop = rd_pop && (count_q == '0);
    // An issue in the same cycle as rd_start must already use the new address.
    issue_addr = rd_start ? start_address : next_addr_q;

    state_d     = state_q;
    active_d    = active_q;
    discard_d   = discard_q;
    next_addr_d = next_addr_q;
    req_addr_d  = req_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underrun_d  = underrun_q;
    mem_d       = mem_q;
    rd_data_d   = 16'h0000;

    if (rd_start) begin
      active_d    = 1'b1;
      next_addr_d = start_address;
    end else if (rd_stop) begin
      active_d = 1'b0;
    end

    // The outstanding request always completes. When the burst changes
    // underneath it, remember to drop its data.
    if (ack_fetch) begin
      discard_d = 1'b0;
    end else if ((state_q == S_FETCH) && flush) begin
      discard_d = 1'b1;
    end

    if (rd_start) begin
      underrun_d = 1'b0;
    end else if (empty_pop) begin
      underrun_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = sram_in;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Register the head word that will be visible after this edge. When the
    // new head is being written this cycle, the FIFO was empty, so take the
    // incoming data directly.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        rd_data_d = sram_in;
      end else begin
        rd_data_d = mem_q[rd_ptr_d];
      end
    end

    case (state_q)
      S_IDLE: begin
        // Issuing only below full guarantees the eventual ack push has room.
        if (active_d && (count_d < CNT_FULL)) begin
          state_d     = S_FETCH;
          req_addr_d  = issue_addr;
          next_addr_d = issue_addr + ADDR_ONE;
        end
      end
      S_FETCH: begin
        if (sram_ack) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      active_q    <= 1'b0;
      discard_q   <= 1'b0;
      next_addr_q <= '0;
      req_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underrun_q  <= 1'b0;
      rd_data_q   <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      discard_q   <= discard_d;
      next_addr_q <= next_addr_d;
      req_addr_q  <= req_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underrun_q  <= underrun_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_valid     = (count_q != '0);
  assign rd_data      = rd_data_q;
  assign underrun     = underrun_q;
  assign sram_req     = (state_q == S_FETCH);
  assign sram_address = (state_q == S_FETCH) ? req_addr_q : '0;

`ifdef PREFETCH_STATS_EN
  logic [15:0] underrun_count_q, underrun_count_d;

  always_comb begin
    underrun_count_d = underrun_count_q;
    if (empty_pop && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_d = underrun_count_q + 16'h0001;
    end
  end

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count_q <= 16'h0000;
    end else begin
      underrun_count_q <= underrun_count_d;
    end
  end

  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_spi_sram_prefetch.sv
// tb/tb_spi_sram_prefetch.sv - directed self-checking bench for spi_sram_prefetch

module tb_spi_sram_prefetch;

  logic        clk200;
  logic        reset_n;
  logic        rd_start;
  logic [19:0] start_address;
  logic        rd_stop;
  logic        rd_pop;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        underrun;
  logic        sram_req;
  logic        sram_ack;
  logic [19:0] sram_address;
  logic [15:0] sram_in;
`ifdef PREFETCH_STATS_EN
  logic [15:0] underrun_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  spi_sram_prefetch #(.DEPTH_LOG2(2), .ADDR_W(20)) dut (
    .clk200        (clk200),
    .reset_n       (reset_n),
    .rd_start      (rd_start),
    .start_address (start_address),
    .rd_stop       (rd_stop),
    .rd_pop        (rd_pop),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .underrun      (underrun),
    .sram_req      (sram_req),
    .sram_ack      (sram_ack),
    .sram_address  (sram_address),
    .sram_in       (sram_in)
`ifdef PREFETCH_STATS_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  initial clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  // SRAM contents: each address holds a distinct, easily recomputed word.
  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk200);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [19:0] addr, input int budget);
    int n = 0;
    while (sram_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(sram_req), 32'd1);
    check({tag, "_addr"}, 32'(sram_address), 32'(addr));
  endtask

  task automatic do_ack(input string tag, input logic [19:0] addr);
    tick();
    tick();
    check({tag, "_stable"}, 32'(sram_address), 32'(addr));
    sram_ack = 1'b1;
    sram_in  = mem_word(addr);
    tick();
    sram_ack = 1'b0;
    sram_in  = 16'h0000;
  endtask

  task automatic serve(input string tag, input logic [19:0] addr);
    wait_req(tag, addr, 4);
    do_ack(tag, addr);
  endtask

  task automatic pulse_pop();
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
  endtask

  task automatic pulse_start(input logic [19:0] addr);
    rd_start      = 1'b1;
    start_address = addr;
    tick();
    rd_start      = 1'b0;
    start_address = '0;
  endtask

  initial begin
    int idle_bad;

    reset_n       = 1'b0;
    rd_start      = 1'b0;
    start_address = '0;
    rd_stop       = 1'b0;
    rd_pop        = 1'b0;
    sram_ack      = 1'b0;
    sram_in       = 16'h0000;
    tick();
    tick();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_addr", 32'(sram_address), 32'd0);
`ifdef PREFETCH_STATS_EN
    check("rst_ucount", 32'(underrun_count), 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    // Burst at 0x10: req one cycle after rd_start, four words fill the FIFO.
    pulse_start(20'h00010);
    check("lat_req", 32'(sram_req), 32'd1);
    serve("b0", 20'h00010);
    check("first_valid", 32'(rd_valid), 32'd1);
    check("first_data", 32'(rd_data), 32'(mem_word(20'h00010)));
    serve("b1", 20'h00011);
    serve("b2", 20'h00012);
    serve("b3", 20'h00013);
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (sram_req !== 1'b0) idle_bad++;
      tick();
    end
    check("full_noreq", 32'(idle_bad), 32'd0);
    check("full_head", 32'(rd_data), 32'(mem_word(20'h00010)));

    // One pop from full: head advances, next request follows quickly.
    pulse_pop();
    check("pop_head", 32'(rd_data), 32'(mem_word(20'h00011)));
    wait_req("refill", 20'h00014, 2);
    do_ack("refill", 20'h00014);

    // Restart near the top of the address space to exercise wrap.
    pulse_start(20'hFFFFE);
    check("flush_valid", 32'(rd_valid), 32'd0);
    serve("w0", 20'hFFFFE);
    serve("w1", 20'hFFFFF);
    serve("w2", 20'h00000);
    serve("w3", 20'h00001);
    check("w_head0", 32'(rd_data), 32'(mem_word(20'hFFFFE)));
    pulse_pop();
    check("w_head1", 32'(rd_data), 32'(mem_word(20'hFFFFF)));
    pulse_pop();
    check("w_head2", 32'(rd_data), 32'(mem_word(20'h00000)));

    // rd_stop while the request for 0x2 is outstanding: it completes, data dropped.
    check("stop_pending", 32'(sram_req), 32'd1);
    rd_stop = 1'b1;
    tick();
    rd_stop = 1'b0;
    check("stop_valid", 32'(rd_valid), 32'd0);
    do_ack("stop_ack", 20'h00002);
    check("stop_nopush", 32'(rd_valid), 32'd0);
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (sram_req !== 1'b0) idle_bad++;
      tick();
    end
    check("stop_idle", 32'(idle_bad), 32'd0);

    // rd_start to 0x100 while the request for 0x50 is pending.
    pulse_start(20'h00050);
    wait_req("p50", 20'h00050, 1);
    pulse_start(20'h00100);
    check("p50_hold", 32'(sram_address), 32'h00050);
    do_ack("p50", 20'h00050);
    check("p50_dropped", 32'(rd_valid), 32'd0);
    serve("n100", 20'h00100);
    check("n100_valid", 32'(rd_valid), 32'd1);
    check("n100_data", 32'(rd_data), 32'(mem_word(20'h00100)));
    serve("n101", 20'h00101);

    // Pop coincident with an ack push at count 2.
    wait_req("co", 20'h00102, 4);
    tick();
    tick();
    sram_ack = 1'b1;
    sram_in  = mem_word(20'h00102);
    rd_pop   = 1'b1;
    tick();
    sram_ack = 1'b0;
    sram_in  = 16'h0000;
    rd_pop   = 1'b0;
    check("co_head", 32'(rd_data), 32'(mem_word(20'h00101)));
    pulse_pop();
    check("co_second", 32'(rd_data), 32'(mem_word(20'h00102)));
    check("co_valid", 32'(rd_valid), 32'd1);
    pulse_pop();
    check("co_empty", 32'(rd_valid), 32'd0);
    check("co_nounder", 32'(underrun), 32'd0);

    // Pop on empty FIFO.
    pulse_pop();
    check("under_set", 32'(underrun), 32'd1);
    check("under_valid", 32'(rd_valid), 32'd0);
`ifdef PREFETCH_STATS_EN
    check("under_count", 32'(underrun_count), 32'd1);
`endif

    // rd_start clears the flag; the pending request for 0x103 is discarded.
    check("pend103", 32'(sram_address), 32'h00103);
    pulse_start(20'h00200);
    check("under_clear", 32'(underrun), 32'd0);
`ifdef PREFETCH_STATS_EN
    check("count_kept", 32'(underrun_count), 32'd1);
`endif
    do_ack("d103", 20'h00103);
    check("d103_dropped", 32'(rd_valid), 32'd0);
    serve("n200", 20'h00200);
    check("n200_data", 32'(rd_data), 32'(mem_word(20'h00200)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
